// File: rtl/async_oneway_tx_scheduler_pkg.sv
// rtl/async_oneway_tx_scheduler_pkg.sv - shared link constants and FSM state type
package async_oneway_tx_scheduler_pkg;

   localparam int MESSAGE_SIZE = 16;
   localparam int LINK_CHUNK_W = 6;
   localparam int LINK_NCHUNK  = (MESSAGE_SIZE + 5) / 6;

   typedef enum logic [2:0] {
      IDLE,
      OPEN,
      HI,
      LO,
      CLOSE
   } tx_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/async_oneway_tx_scheduler_rr_arbiter.sv
// rtl/async_oneway_tx_scheduler_rr_arbiter.sv - combinational round-robin pick
// Returns the first set request at or after i_ptr, wrapping cyclically.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PTR_W-1:0]   o_index,
   output logic               o_valid
);
   logic [PTR_W-1:0] w_idx_hi;
   logic [PTR_W-1:0] w_idx_lo;
   logic             w_hit_hi;

   // Descending scan: the last hit written is the lowest qualifying index.
   always_comb begin
      w_idx_hi = '0;
      w_idx_lo = '0;
      w_hit_hi = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_idx_lo = PTR_W'(i);
            if (i >= int'(i_ptr)) begin
               w_idx_hi = PTR_W'(i);
               w_hit_hi = 1'b1;
            end
         end
      end
   end

   assign o_valid = |i_req;
   assign o_index = w_hit_hi ? w_idx_hi : w_idx_lo;
   assign o_grant = o_valid ? (NUM_REQ'(1) << o_index) : '0;

endmodule

// File: rtl/async_oneway_tx_scheduler.sv
// rtl/async_oneway_tx_scheduler.sv - round-robin send sequencer for the one-way 6-bit link
// Frames one granted message as return-to-zero chunks inside a transmit_ctrl envelope.
module async_oneway_tx_scheduler
   import async_oneway_tx_scheduler_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int HOLD_CYCLES  = 16,
   parameter int GUARD_CYCLES = 16,
   parameter int GAP_CYCLES   = 16
) (
   input  logic                            i_clk_send,
   input  logic                            i_rst,
   input  logic [NUM_REQ-1:0]              i_req,
   input  logic [NUM_REQ*MESSAGE_SIZE-1:0] i_msg,
   output logic [NUM_REQ-1:0]              o_ack,
   output logic                            o_done,
   output logic                            o_busy,
   output logic                            o_transmit_ctrl,
   output logic                            o_packet_pulse,
   output logic [LINK_CHUNK_W-1:0]         o_dout
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GUARD_CYCLES, GAP_CYCLES) + 1);
   localparam int IDX_W = $clog2(LINK_NCHUNK + 1);
   localparam int PAD_W = LINK_NCHUNK * LINK_CHUNK_W;

   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LINK_NCHUNK - 1);

   tx_state_t                r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [IDX_W-1:0]         r_idx;
   logic [PTR_W-1:0]         r_ptr;
   logic [MESSAGE_SIZE-1:0]  r_msg;
   logic [NUM_REQ-1:0]       r_ack;
   logic                     r_done;
   logic                     r_busy;
   logic                     r_tc;
   logic                     r_pp;
   logic [LINK_CHUNK_W-1:0]  r_dout;

   logic [NUM_REQ-1:0]       w_grant;
   logic [PTR_W-1:0]         w_index;
   logic                     w_valid;
   logic [PTR_W-1:0]         w_ptr_next;
   logic [MESSAGE_SIZE-1:0]  w_sel_msg;
   logic [PAD_W-1:0]         w_padded;
   logic [LINK_CHUNK_W-1:0]  w_chunks [LINK_NCHUNK];
   logic [LINK_CHUNK_W-1:0]  w_chunk;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_index (w_index),
      .o_valid (w_valid)
   );

   always_comb begin
      w_sel_msg = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_index == PTR_W'(i)) w_sel_msg = i_msg[i*MESSAGE_SIZE +: MESSAGE_SIZE];
      end
   end

   assign w_ptr_next = (int'(w_index) == NUM_REQ - 1) ? '0 : w_index + 1'b1;

   // Top pad bits of the last chunk are zero.
   assign w_padded = PAD_W'(r_msg);
   for (genvar j = 0; j < LINK_NCHUNK; j++) begin : g_chunk
      assign w_chunks[j] = w_padded[j*LINK_CHUNK_W +: LINK_CHUNK_W];
   end
   assign w_chunk = w_chunks[r_idx];

   // Level outputs follow the current state with one cycle of register delay;
   // ack and done are registered at the transition that causes them.
   always_ff @(posedge i_clk_send) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_msg   <= '0;
         r_ack   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_tc    <= 1'b0;
         r_pp    <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_tc   <= (r_state == OPEN) || (r_state == HI) || (r_state == LO);
         r_pp   <= (r_state == HI);
         r_dout <= (r_state == HI) ? w_chunk : '0;
         r_busy <= (r_state != IDLE);
         r_ack  <= '0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_msg   <= w_sel_msg;
                  r_ack   <= w_grant;
                  r_ptr   <= w_ptr_next;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= OPEN;
               end
            end
            OPEN: begin
               if (r_cnt == GUARD_LAST) begin
                  r_cnt   <= '0;
                  r_state <= HI;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HI: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt   <= '0;
                  r_state <= LO;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LO: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_idx   <= '0;
                     r_state <= CLOSE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= HI;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CLOSE: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_ack           = r_ack;
   assign o_done          = r_done;
   assign o_busy          = r_busy;
   assign o_transmit_ctrl = r_tc;
   assign o_packet_pulse  = r_pp;
   assign o_dout          = r_dout;

endmodule

// File: tb/tb_async_oneway_tx_scheduler.sv
// tb/tb_async_oneway_tx_scheduler.sv - scoreboard bench for async_oneway_tx_scheduler
module tb_async_oneway_tx_scheduler;
   localparam int N  = 2;
   localparam int MS = 16;
   localparam int NC = 3;
   localparam int G  = 4;
   localparam int H  = 4;
   localparam int P  = 4;
   localparam int TC_END = G + 2 * H * NC;
   localparam int L  = TC_END + P;

   logic          clk = 1'b0;
   logic          rst;
   logic          rst_q = 1'b1;
   logic [N-1:0]  req;
   logic [N*MS-1:0] msg;
   logic [N-1:0]  o_ack;
   logic          o_done, o_busy, o_transmit_ctrl, o_packet_pulse;
   logic [5:0]    o_dout;

   int checks = 0;
   int errors = 0;
   int rr_ptr = 0;
   int exp_g_q[$];
   logic [MS-1:0] exp_m_q[$];

   async_oneway_tx_scheduler #(
      .NUM_REQ      (N),
      .HOLD_CYCLES  (H),
      .GUARD_CYCLES (G),
      .GAP_CYCLES   (P)
   ) dut (
      .i_clk_send      (clk),
      .i_rst           (rst),
      .i_req           (req),
      .i_msg           (msg),
      .o_ack           (o_ack),
      .o_done          (o_done),
      .o_busy          (o_busy),
      .o_transmit_ctrl (o_transmit_ctrl),
      .o_packet_pulse  (o_packet_pulse),
      .o_dout          (o_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rst_q <= rst;

   // Expected {ack, done, busy, ctrl, pulse, dout} k cycles after the ack cycle.
   function automatic logic [11:0] exp_wave(input int k, input int g, input logic [MS-1:0] m);
      logic [N-1:0] a;
      logic d, b, t, p;
      logic [5:0] dv;
      logic [17:0] pad;
      int o;
      pad = {2'b00, m};
      a = '0; d = 0; b = 0; t = 0; p = 0; dv = '0;
      if (k == 0) a = N'(1 << g);
      t = (k >= 1 && k <= TC_END);
      b = (k >= 1 && k <= L);
      d = (k == L);
      if (k >= 1 + G && k < 1 + TC_END) begin
         o = k - 1 - G;
         if (o % (2 * H) < H) begin
            p  = 1'b1;
            dv = pad[6 * (o / (2 * H)) +: 6];
         end
      end
      return {a, d, b, t, p, dv};
   endfunction

   function automatic int predict(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
      end
      return -1;
   endfunction

   bit            in_frame = 0;
   int            fk, cur_g, nch;
   logic [MS-1:0] cur_m;
   logic [17:0]   asm_buf;
   logic          pp_q = 1'b0;
   logic [11:0]   act, expv;

   always @(negedge clk) begin
      act = {o_ack, o_done, o_busy, o_transmit_ctrl, o_packet_pulse, o_dout};
      checks++;
      if ((o_dout != 0 && !o_packet_pulse) || (o_packet_pulse && !o_transmit_ctrl)) begin
         errors++;
         $display("FAIL framing_invariant: dout=%h pulse=%b ctrl=%b", o_dout, o_packet_pulse, o_transmit_ctrl);
      end
      if (rst_q) begin
         in_frame = 0;
         checks++;
         if (act !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 000", act);
         end
      end else begin
         if (!in_frame) begin
            expv = 12'h000;
            if (o_ack != 0) begin
               if (exp_g_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_ack: got %b want none", o_ack);
               end else begin
                  cur_g = exp_g_q.pop_front();
                  cur_m = exp_m_q.pop_front();
                  in_frame = 1; fk = 0; nch = 0; asm_buf = '0;
                  expv = exp_wave(0, cur_g, cur_m);
               end
            end
         end else begin
            fk++;
            expv = exp_wave(fk, cur_g, cur_m);
            if (o_packet_pulse && !pp_q && nch < NC) begin
               asm_buf[6 * nch +: 6] = o_dout;
               nch++;
            end
         end
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL wave(k=%0d,inframe=%0d): got %h want %h", fk, in_frame, act, expv);
         end
         if (in_frame && fk == L) begin
            checks++;
            if (nch != NC || asm_buf !== {2'b00, cur_m}) begin
               errors++;
               $display("FAIL reassembled_msg: got %h (%0d chunks) want %h", asm_buf, nch, cur_m);
            end
            in_frame = 0;
         end
      end
      pp_q = o_packet_pulse;
   end

   // Push the expected grant for the current req/msg, then wait for the ack.
   task automatic issue();
      int  g;
      bit  seen;
      g = predict(req);
      if (g < 0) return;
      exp_g_q.push_back(g);
      exp_m_q.push_back(msg[g*MS +: MS]);
      rr_ptr = (g + 1) % N;
      seen = 0;
      for (int c = 0; c < 2 * L + 8 && !seen; c++) begin
         @(negedge clk);
         if (o_ack != 0) seen = 1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got none want ack[%0d]", g);
         void'(exp_g_q.pop_back());
         void'(exp_m_q.pop_back());
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int c = 0; c < 2 * L + 8 && !seen; c++) begin
         @(negedge clk);
         if (o_done) seen = 1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout: got none want done");
      end
   endtask

   initial begin
      bit got;
      int rises;
      logic pprev;
      rst = 1'b1; req = '0; msg = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      req = 2'b01; msg = {16'h0000, 16'hBEEF};
      issue();
      msg[15:0] = 16'hFFFF;
      issue();
      req = 2'b11; msg = {16'h1234, 16'h5678};
      for (int f = 0; f < 4; f++) begin
         issue();
         msg = $urandom;
      end
      for (int f = 0; f < 14; f++) begin
         issue();
         req = 2'($urandom_range(1, 3));
         msg = $urandom;
      end

      req = 2'b01; msg = $urandom;
      issue();
      wait_done();
      // Leave the DUT pointer at 1, then reset during the second chunk.
      req = 2'b01; msg = $urandom;
      issue();
      req = 2'b00;
      rises = 0; pprev = 1'b0; got = 0;
      for (int c = 0; c < 2 * L && !got; c++) begin
         @(negedge clk);
         if (o_packet_pulse && !pprev) rises++;
         if (rises == 2) got = 1;
         pprev = o_packet_pulse;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL second_hi_timeout: got %0d pulses want 2", rises);
      end
      rst = 1'b1;
      exp_g_q.delete();
      exp_m_q.delete();
      rr_ptr = 0;
      @(negedge clk);
      rst = 1'b0;
      req = 2'b11; msg = $urandom;
      issue();
      req = 2'b00;
      wait_done();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_g_q.size() != 0 || in_frame) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_g_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
